// File: rtl/ddr2_btm_local_traffic_driver.sv
// ddr2_btm_local_traffic_driver
// Board-test initiator for the DDR2 controller local interface. A start pulse
// waits for calibration, writes a deterministic pattern over NUM_WORDS linear
// word addresses, reads them back in order and compares every returned beat.
// Ports:
//   clk, reset            half-rate clock, asynchronous active-high reset
//   start                 single-cycle start pulse (ignored while busy)
//   local_init_done       controller calibration complete
//   local_ready           controller accepts the current request
//   local_rdata_valid/local_rdata   read return beats
//   local_read_req/local_write_req/local_burstbegin   request strobes
//   local_row/bank/col_addr, local_wdata, local_be    request payload
//   local_size/autopch/refresh/powerdn/self_rfsh/cs   tied controls
//   busy, done, pass, err_count, first_fail_idx       test status
module ddr2_btm_local_traffic_driver #(
    parameter int          DATA_WIDTH      = 128,
    parameter int          ROW_BITS        = 13,
    parameter int          BANK_BITS       = 2,
    parameter int          COL_BITS        = 9,
    parameter int          NUM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] SEED            = 32'hA5C3_0F1E
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    local_init_done,
    input  logic                    local_ready,
    input  logic                    local_rdata_valid,
    input  logic [DATA_WIDTH-1:0]   local_rdata,
    output logic                    local_read_req,
    output logic                    local_write_req,
    output logic                    local_burstbegin,
    output logic                    local_size,
    output logic                    local_autopch_req,
    output logic                    local_refresh_req,
    output logic                    local_powerdn_req,
    output logic                    local_self_rfsh_req,
    output logic                    local_cs_addr,
    output logic [ROW_BITS-1:0]     local_row_addr,
    output logic [BANK_BITS-1:0]    local_bank_addr,
    output logic [COL_BITS-1:0]     local_col_addr,
    output logic [DATA_WIDTH-1:0]   local_wdata,
    output logic [DATA_WIDTH/8-1:0] local_be,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [23:0]             first_fail_idx
);

    localparam int IDX_W = ROW_BITS + BANK_BITS + COL_BITS;
    localparam int LANES = DATA_WIDTH / 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]       MAX_OUT  = 8'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Word k, lane i = (4k + i) ^ SEED, modulo 2^32.
    function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [IDX_W-1:0] k);
        logic [DATA_WIDTH-1:0] w;
        logic [31:0]           base;
        base = 32'(k) << 2;
        w    = '0;
        for (int i = 0; i < LANES; i++) begin
            w[32*i +: 32] = (base + 32'(i)) ^ SEED;
        end
        return w;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic [IDX_W-1:0]      ret_idx_r, ret_idx_nxt_s;
    logic [7:0]            outstanding_r, outstanding_nxt_s;
    logic [15:0]           err_count_r, err_nxt_s;
    logic [23:0]           first_fail_r, ffi_nxt_s;
    logic                  wr_req_r, wr_req_nxt_s;
    logic                  rd_req_r, rd_req_nxt_s;
    logic                  burst_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  pass_r, pass_nxt_s;
    logic                  clear_s;
    logic                  wr_acc_s, rd_acc_s;
    logic                  beat_ok_s, beat_bad_s;

    assign wr_acc_s  = wr_req_r & local_ready;
    assign rd_acc_s  = rd_req_r & local_ready;
    // A beat with nothing outstanding is spurious: it is an error and does
    // not consume a return index.
    assign beat_ok_s = local_rdata_valid & (outstanding_r != 8'd0);
    assign beat_bad_s = (local_rdata_valid & (outstanding_r == 8'd0)) |
                        (beat_ok_s & (local_rdata != pattern_word(ret_idx_r)));

    // Next-state and word index sequencing.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        clear_s     = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt_s = S_WAIT;
                    idx_nxt_s   = '0;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_WAIT: begin
                if (local_init_done) begin
                    state_nxt_s = S_WRITE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_WRITE: begin
                if (wr_acc_s && (idx_r == LAST_IDX)) begin
                    state_nxt_s = S_READ;
                    idx_nxt_s   = '0;
                end else if (wr_acc_s) begin
                    idx_nxt_s = idx_r + 1'b1;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            S_READ: begin
                if (rd_acc_s && (idx_r == LAST_IDX)) begin
                    state_nxt_s = S_DRAIN;
                end else if (rd_acc_s) begin
                    idx_nxt_s = idx_r + 1'b1;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            S_DRAIN: begin
                if (outstanding_r == 8'd0) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Counters, compare results and next values of the registered outputs.
    always_comb begin
        ret_idx_nxt_s     = ret_idx_r;
        outstanding_nxt_s = outstanding_r;
        err_nxt_s         = err_count_r;
        ffi_nxt_s         = first_fail_r;
        if (clear_s) begin
            ret_idx_nxt_s     = '0;
            outstanding_nxt_s = 8'd0;
            err_nxt_s         = 16'd0;
            ffi_nxt_s         = 24'd0;
        end else begin
            if (beat_ok_s) begin
                ret_idx_nxt_s = ret_idx_r + 1'b1;
            end else begin
                ret_idx_nxt_s = ret_idx_r;
            end
            case ({rd_acc_s, beat_ok_s})
                2'b10:   outstanding_nxt_s = outstanding_r + 8'd1;
                2'b01:   outstanding_nxt_s = outstanding_r - 8'd1;
                default: outstanding_nxt_s = outstanding_r;
            endcase
            if (beat_bad_s && (err_count_r != 16'hFFFF)) begin
                err_nxt_s = err_count_r + 16'd1;
            end else begin
                err_nxt_s = err_count_r;
            end
            // err_count saturates and never returns to zero, so zero marks
            // "no error seen yet".
            if (beat_bad_s && (err_count_r == 16'd0)) begin
                ffi_nxt_s = 24'(ret_idx_r);
            end else begin
                ffi_nxt_s = first_fail_r;
            end
        end
        wr_req_nxt_s = (state_nxt_s == S_WRITE);
        // Read requests start the cycle after entering READ, and a pending
        // request can never be withdrawn because outstanding cannot rise
        // without an accept.
        rd_req_nxt_s = (state_r == S_READ) && (state_nxt_s == S_READ) &&
                       (outstanding_nxt_s < MAX_OUT);
        busy_nxt_s   = (state_nxt_s == S_WAIT) || (state_nxt_s == S_WRITE) ||
                       (state_nxt_s == S_READ) || (state_nxt_s == S_DRAIN);
        done_nxt_s   = (state_nxt_s == S_DONE);
        pass_nxt_s   = done_nxt_s && (err_nxt_s == 16'd0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            idx_r         <= '0;
            ret_idx_r     <= '0;
            outstanding_r <= 8'd0;
            err_count_r   <= 16'd0;
            first_fail_r  <= 24'd0;
            wr_req_r      <= 1'b0;
            rd_req_r      <= 1'b0;
            burst_r       <= 1'b0;
            wdata_r       <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            ret_idx_r     <= ret_idx_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            err_count_r   <= err_nxt_s;
            first_fail_r  <= ffi_nxt_s;
            wr_req_r      <= wr_req_nxt_s;
            rd_req_r      <= rd_req_nxt_s;
            burst_r       <= wr_req_nxt_s | rd_req_nxt_s;
            wdata_r       <= pattern_word(idx_nxt_s);
            busy_r        <= busy_nxt_s;
            done_r        <= done_nxt_s;
            pass_r        <= pass_nxt_s;
        end
    end

    assign local_read_req      = rd_req_r;
    assign local_write_req     = wr_req_r;
    assign local_burstbegin    = burst_r;
    assign local_size          = 1'b1;
    assign local_autopch_req   = 1'b0;
    assign local_refresh_req   = 1'b0;
    assign local_powerdn_req   = 1'b0;
    assign local_self_rfsh_req = 1'b0;
    assign local_cs_addr       = 1'b0;
    assign local_row_addr      = idx_r[IDX_W-1 -: ROW_BITS];
    assign local_bank_addr     = idx_r[BANK_BITS+COL_BITS-1 : COL_BITS];
    assign local_col_addr      = idx_r[COL_BITS-1:0];
    assign local_wdata         = wdata_r;
    assign local_be            = '1;
    assign busy                = busy_r;
    assign done                = done_r;
    assign pass                = pass_r;
    assign err_count           = err_count_r;
    assign first_fail_idx      = first_fail_r;

endmodule
